// File: rtl/dropout_sequencer.sv
// dropout_sequencer: builds a per-frame keep mask from a 16-bit LFSR against a
// programmable drop rate, then streams NUM_NEURONS activations, zeroing dropped ones.
// Latency: 1 cycle from input acceptance to out_valid. Backpressure: in_ready drops
// while the single output register is full and out_ready is low; GEN never stalls.
// Ports: clk/reset (sync, active-high); cfg_we/cfg_rate/cfg_train shadow config write;
//   in_valid/in_data/in_ready input stream; out_valid/out_data/out_ready/out_last/
//   out_dropped output stream; busy (mask generation); frame_cnt (completed frames).
module dropout_sequencer #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          NUM_NEURONS = 8,
  parameter int          DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_rate,
  input  logic              cfg_train,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_dropped,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GEN    = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t                 state, state_n;
  logic [15:0]            lfsr;
  logic [7:0]             shadow_rate, act_rate;
  logic                   shadow_train, act_train;
  logic [NUM_NEURONS-1:0] mask;
  logic [IDX_W-1:0]       idx;
  logic                   in_acc, last_acc;

  assign in_acc   = in_valid && in_ready;
  assign last_acc = in_acc && (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and handshake outputs. Frame-boundary decisions read the shadow
  // train bit because that is the value being loaded into the active copy.
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        state_n = shadow_train ? GEN : STREAM;
      end
      GEN: begin
        busy = 1'b1;
        if (idx == LAST_IDX) state_n = STREAM;
      end
      STREAM: begin
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && (idx == LAST_IDX))
          state_n = shadow_train ? GEN : STREAM;
      end
      default: state_n = IDLE;
    endcase
  end

  // Config, LFSR, mask and beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr         <= SEED_EFF;
      shadow_rate  <= 8'd128;
      shadow_train <= 1'b1;
      act_rate     <= 8'd128;
      act_train    <= 1'b1;
      mask         <= '1;
      idx          <= '0;
      frame_cnt    <= 8'd0;
    end else begin
      if (cfg_we) begin
        shadow_rate  <= cfg_rate;
        shadow_train <= cfg_train;
      end
      case (state)
        IDLE: begin
          act_rate  <= shadow_rate;
          act_train <= shadow_train;
          idx       <= '0;
          if (!shadow_train) mask <= '1;
        end
        GEN: begin
          mask[idx] <= (lfsr[7:0] >= act_rate);
          lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
          idx       <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
        STREAM: begin
          if (last_acc) begin
            idx       <= '0;
            frame_cnt <= frame_cnt + 8'd1;
            act_rate  <= shadow_rate;
            act_train <= shadow_train;
            if (!shadow_train) mask <= '1;
          end else if (in_acc) begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Single output stage. A simultaneous accept and drain reloads in place, so
  // out_valid stays high and throughput is one beat per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      out_dropped <= 1'b0;
    end else if (in_acc) begin
      out_valid   <= 1'b1;
      out_data    <= mask[idx] ? in_data : '0;
      out_last    <= (idx == LAST_IDX);
      out_dropped <= !mask[idx];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
